// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for load_store_unit.
// slave is the unit's view; master is the execute stage plus memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  DataType;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, DataType, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               resp_valid, resp_rdata, resp_err, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, DataType, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-access load/store unit: byte-lane alignment, byte enables, zero-extended loads.
// Define LSU_TIMEOUT_EN to abort accesses that get no mem_ack within TIMEOUT_CYCLES.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_write;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_misaligned;
    logic [3:0]  w_be_in;
    logic [31:0] w_wdata_in;
    logic [31:0] w_rdata_shift;
    logic [31:0] w_load_data;
    logic        w_timeout;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    // Size code 11 is handled as a word everywhere.
    always_comb begin
        w_misaligned = 1'b0;
        w_be_in      = 4'b1111;
        w_wdata_in   = bus.req_wdata;
        case (bus.DataType)
            2'b01: begin
                w_be_in    = 4'b0001 << bus.req_addr[1:0];
                w_wdata_in = {24'b0, bus.req_wdata[7:0]} << {bus.req_addr[1:0], 3'b000};
            end
            2'b10: begin
                w_misaligned = bus.req_addr[0];
                w_be_in      = 4'b0011 << bus.req_addr[1:0];
                w_wdata_in   = {16'b0, bus.req_wdata[15:0]} << {bus.req_addr[1:0], 3'b000};
            end
            default: w_misaligned = (bus.req_addr[1:0] != 2'b00);
        endcase
    end

    assign w_rdata_shift = bus.mem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'b01:   w_load_data = {24'b0, w_rdata_shift[7:0]};
            2'b10:   w_load_data = {16'b0, w_rdata_shift[15:0]};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_cnt;

    // Counts REQ cycles already spent without ack; the last allowed cycle aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ && !bus.mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_REQ) && !bus.mem_ack &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.req_valid) w_state_next = w_misaligned ? S_RESP : S_REQ;
            S_REQ:  if (bus.mem_ack || w_timeout) w_state_next = S_RESP;
            S_RESP: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_write <= bus.req_write;
            r_off   <= bus.req_addr[1:0];
            r_size  <= bus.DataType;
            r_addr  <= {bus.req_addr[31:2], 2'b00};
            r_be    <= w_be_in;
            r_wdata <= w_wdata_in;
            r_rdata <= '0;
            r_err   <= w_misaligned;
        end else if (r_state == S_REQ) begin
            if (bus.mem_ack) begin
                r_rdata <= r_write ? 32'h0 : w_load_data;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Bus outputs are gated by state so they read zero outside their phase.
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mem_req    = (r_state == S_REQ);
    assign bus.mem_we     = (r_state == S_REQ) && r_write;
    assign bus.mem_addr   = (r_state == S_REQ) ? r_addr  : 32'h0;
    assign bus.mem_be     = (r_state == S_REQ) ? r_be    : 4'h0;
    assign bus.mem_wdata  = (r_state == S_REQ) ? r_wdata : 32'h0;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;
    assign bus.resp_err   = (r_state == S_RESP) && r_err;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, memory responder, response monitor.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n;
    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        time         t_acc;
    } resp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          delay;
        logic [31:0] rdata;
    } mem_exp_t;

    resp_exp_t resp_q[$];
    mem_exp_t  mem_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic stray_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder: checks the request on its first REQ cycle, acks after delay waits.
    initial begin
        mem_exp_t cur;
        bit in_acc = 0;
        int waits = 0;
        cur = '{default: 0};
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!bus.mem_req) begin
                in_acc = 0;
            end else begin
                if (!in_acc) begin
                    if (mem_q.size() == 0) begin
                        chk("unexpected_mem_req", {31'b0, bus.mem_req}, 32'h0);
                        cur = '{addr: 0, be: 0, wdata: 0, we: 0, delay: 0, rdata: 0};
                    end else begin
                        cur = mem_q.pop_front();
                        chk("mem_addr",  bus.mem_addr, cur.addr);
                        chk("mem_be",    {28'b0, bus.mem_be}, {28'b0, cur.be});
                        chk("mem_we",    {31'b0, bus.mem_we}, {31'b0, cur.we});
                        chk("mem_wdata", bus.mem_wdata, cur.wdata);
                    end
                    in_acc = 1;
                    waits = 0;
                end
                if (waits == cur.delay) begin
                    chk("mem_be_at_ack", {28'b0, bus.mem_be}, {28'b0, cur.be});
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = cur.rdata;
                end else begin
                    waits++;
                end
            end
            if (stray_ack) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = 32'h5555AAAA;
            end
        end
    end

    // Response monitor.
    initial begin
        resp_exp_t e;
        int lat;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
                end else begin
                    e = resp_q.pop_front();
                    lat = int'(($time - e.t_acc - 5) / 10) + 1;
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
                    chk("resp_latency", lat, e.lat);
                    $display("resp: rdata=%h err=%0d latency=%0d", bus.resp_rdata, bus.resp_err, lat);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] dt, input int delay, input logic [31:0] rdata,
                         input logic mis, input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                         input logic e_err, input int e_lat, input bit want_resp);
        int budget = 0;
        @(negedge clk);
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.DataType  = dt;
        bus.req_valid = 1'b1;
        while (bus.req_ready !== 1'b1) begin
            @(negedge clk);
            budget++;
            if (budget > 200) begin
                chk("accept_timeout", {31'b0, bus.req_ready}, 32'h1);
                bus.req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (!mis)
            mem_q.push_back('{addr: e_addr, be: e_be, wdata: e_wdata, we: wr, delay: delay, rdata: rdata});
        if (want_resp)
            resp_q.push_back('{rdata: e_rdata, err: e_err, lat: e_lat, t_acc: $time});
        $display("issue: we=%0d addr=%h wdata=%h dt=%0d delay=%0d", wr, addr, wdata, dt, delay);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int budget;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.DataType  = 2'b00;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_req_ready",  {31'b0, bus.req_ready},  32'h1);
        chk("rst_busy",       {31'b0, bus.busy},       32'h0);
        chk("rst_mem_req",    {31'b0, bus.mem_req},    32'h0);
        chk("rst_mem_we",     {31'b0, bus.mem_we},     32'h0);
        chk("rst_mem_be",     {28'b0, bus.mem_be},     32'h0);
        chk("rst_mem_addr",   bus.mem_addr,            32'h0);
        chk("rst_mem_wdata",  bus.mem_wdata,           32'h0);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata,          32'h0);
        chk("rst_resp_err",   {31'b0, bus.resp_err},   32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //    wr addr          wdata         dt     dly rdata         mis e_addr        e_be     e_wdata       e_rdata       err lat
        issue(0, 32'h00000100, 32'h0,        2'b00, 0, 32'hDEADBEEF, 0, 32'h00000100, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 2, 1);
        issue(0, 32'h00000103, 32'h0,        2'b01, 0, 32'h80AABBCC, 0, 32'h00000100, 4'b1000, 32'h0,        32'h00000080, 0, 2, 1);
        issue(1, 32'h00000202, 32'h1234ABCD, 2'b10, 3, 32'h0,        0, 32'h00000200, 4'b1100, 32'hABCD0000, 32'h0,        0, 5, 1);
        issue(0, 32'h00000101, 32'h0,        2'b00, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1, 1);
        issue(0, 32'h00000102, 32'h0,        2'b10, 1, 32'h11223344, 0, 32'h00000100, 4'b1100, 32'h0,        32'h00001122, 0, 3, 1);
        issue(1, 32'h00000101, 32'hFFFFFF5A, 2'b01, 0, 32'h0,        0, 32'h00000100, 4'b0010, 32'h00005A00, 32'h0,        0, 2, 1);
        issue(1, 32'h00000204, 32'hCAFEF00D, 2'b11, 2, 32'h0,        0, 32'h00000204, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 4, 1);
        issue(0, 32'h00000103, 32'h0,        2'b10, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1, 1);
        issue(0, 32'h00000100, 32'h0,        2'b01, 0, 32'h123456F0, 0, 32'h00000100, 4'b0001, 32'h0,        32'h000000F0, 0, 2, 1);
        issue(0, 32'h00000100, 32'h0,        2'b10, 0, 32'hAAAA7788, 0, 32'h00000100, 4'b0011, 32'h0,        32'h00007788, 0, 2, 1);
        issue(0, 32'h00000302, 32'h0,        2'b11, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1, 1);
`ifdef LSU_TIMEOUT_EN
        issue(0, 32'h00000400, 32'h0,        2'b00, 1000, 32'h0,     0, 32'h00000400, 4'b1111, 32'h0,        32'h0,        1, 5, 1);
        issue(0, 32'h00000400, 32'h0,        2'b00, 3, 32'h01020304, 0, 32'h00000400, 4'b1111, 32'h0,        32'h01020304, 0, 5, 1);
`endif
        budget = 0;
        while (resp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_before_reset", resp_q.size(), 32'h0);

        // Reset in the middle of an access that memory never acknowledges.
        issue(0, 32'h00000500, 32'h0, 2'b00, 1000, 32'h0, 0, 32'h00000500, 4'b1111, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        chk("mid_mem_req", {31'b0, bus.mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req",   {31'b0, bus.mem_req},   32'h0);
        chk("async_busy",      {31'b0, bus.busy},      32'h0);
        chk("async_mem_addr",  bus.mem_addr,           32'h0);
        chk("async_req_ready", {31'b0, bus.req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        stray_ack = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {31'b0, bus.busy}, 32'h0);

        // Unit must still work normally afterwards.
        issue(0, 32'h00000600, 32'h0, 2'b01, 0, 32'h0000C300, 0, 32'h00000600, 4'b0001, 32'h0, 32'h00000000, 0, 2, 1);
        issue(0, 32'h00000601, 32'h0, 2'b01, 0, 32'h0000C300, 0, 32'h00000600, 4'b0010, 32'h0, 32'h000000C3, 0, 2, 1);
        budget = 0;
        while (resp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("final_drain", resp_q.size(), 32'h0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
